// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one low-level I2C master between two command requesters. Requests
// are arbitrated round-robin. The winning command is latched onto the master
// command bus, and a one-cycle start pulse is issued. The arbiter then waits
// for a rising edge on the master's done level. Completion is returned to the
// owner as a one-cycle ack, with read data and an error flag. Illegal commands
// and master timeouts complete with err = 1.
//
// Ports
//   clock                      : single clock; all logic on posedge
//   rst                        : synchronous active-high reset
//   req0/1                     : request levels, fields stable until ack
//   dev_addr0/1, reg_addr0/1   : 7-bit device / 8-bit register address
//   num_bytes0/1, write0/1     : transfer length and direction (1 = write)
//   wdata0/1                   : write payload, byte k at [8k+7:8k]
//   ack0/1                     : one-cycle completion pulse to the owner
//   err                        : valid with ack; timeout or illegal command
//   rdata                      : read data, held until the next ack
//   busy                       : high whenever not idle
//   owner                      : current or last granted requester
//   m_disable, m_start         : master control (m_start is `communicate`)
//   m_dev_addr .. m_wdata      : latched command towards the master
//   m_done, m_rdata            : master done level and read data
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int MAX_BYTES = 6,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [6:0]             dev_addr0,
  input  logic [6:0]             dev_addr1,
  input  logic [7:0]             reg_addr0,
  input  logic [7:0]             reg_addr1,
  input  logic [3:0]             num_bytes0,
  input  logic [3:0]             num_bytes1,
  input  logic                   write0,
  input  logic                   write1,
  input  logic [8*MAX_BYTES-1:0] wdata0,
  input  logic [8*MAX_BYTES-1:0] wdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   err,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   owner,
  output logic                   m_disable,
  output logic                   m_start,
  output logic [6:0]             m_dev_addr,
  output logic [7:0]             m_addr,
  output logic [3:0]             m_num_bytes,
  output logic                   m_write,
  output logic [8*MAX_BYTES-1:0] m_wdata,
  input  logic                   m_done,
  input  logic [8*MAX_BYTES-1:0] m_rdata
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0]    MAX_NUM = 4'(MAX_BYTES);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state;
  logic          last_owner;
  logic          m_done_q;
  logic [CW-1:0] count;

  // Grant selection and the selected requester's command fields.
  logic          grant_valid;
  logic          grant_idx;
  logic [6:0]    sel_dev;
  logic [7:0]    sel_reg;
  logic [3:0]    sel_num;
  logic          sel_write;
  logic [DW-1:0] sel_wdata;
  logic          sel_illegal;
  logic          done_edge;
  logic          timed_out;

  // Round-robin choice: on a tie the requester that did not own last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_owner;
    end else if (req1) begin
      grant_idx = 1'b1;
    end else begin
      grant_idx = 1'b0;
    end
  end

  // Mux the grantee's fields and classify the command.
  always_comb begin
    sel_dev   = dev_addr0;
    sel_reg   = reg_addr0;
    sel_num   = num_bytes0;
    sel_write = write0;
    sel_wdata = wdata0;
    if (grant_idx) begin
      sel_dev   = dev_addr1;
      sel_reg   = reg_addr1;
      sel_num   = num_bytes1;
      sel_write = write1;
      sel_wdata = wdata1;
    end else begin
      sel_dev   = dev_addr0;
      sel_reg   = reg_addr0;
      sel_num   = num_bytes0;
      sel_write = write0;
      sel_wdata = wdata0;
    end
    // Too long for the data bus, or a read of nothing.
    sel_illegal = (sel_num > MAX_NUM) || (!sel_write && (sel_num == 4'd0));
  end

  // Only a fresh rising edge of done counts; a level left high is ignored.
  assign done_edge = m_done & ~m_done_q;
  assign timed_out = (count == TO_VAL);

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      m_done_q    <= 1'b0;
      count       <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      owner       <= 1'b0;
      m_disable   <= 1'b1;
      m_start     <= 1'b0;
      m_dev_addr  <= 7'd0;
      m_addr      <= 8'd0;
      m_num_bytes <= 4'd0;
      m_write     <= 1'b0;
      m_wdata     <= '0;
    end else begin
      m_done_q <= m_done;
      case (state)
        IDLE: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          err       <= 1'b0;
          m_start   <= 1'b0;
          m_disable <= 1'b1;
          if (grant_valid) begin
            owner       <= grant_idx;
            busy        <= 1'b1;
            m_dev_addr  <= sel_dev;
            m_addr      <= sel_reg;
            m_num_bytes <= sel_num;
            m_write     <= sel_write;
            m_wdata     <= sel_wdata;
            if (sel_illegal) begin
              // Never reaches the master: complete with error next cycle.
              state <= FINISH;
              err   <= 1'b1;
              ack0  <= ~grant_idx;
              ack1  <= grant_idx;
            end else begin
              state     <= ISSUE;
              m_start   <= 1'b1;
              m_disable <= 1'b0;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ISSUE: begin
          m_start <= 1'b0;
          count   <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          // Done is checked first so it wins over a simultaneous timeout.
          if (done_edge) begin
            if (!m_write) begin
              rdata <= m_rdata;
            end
            err       <= 1'b0;
            ack0      <= ~owner;
            ack1      <= owner;
            m_disable <= 1'b1;
            state     <= FINISH;
          end else if (timed_out) begin
            err       <= 1'b1;
            ack0      <= ~owner;
            ack1      <= owner;
            m_disable <= 1'b1;
            state     <= FINISH;
          end else begin
            count <= count + CNT_ONE;
          end
        end

        FINISH: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          err        <= 1'b0;
          busy       <= 1'b0;
          m_disable  <= 1'b1;
          last_owner <= owner;
          state      <= IDLE;
        end

        default: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          m_start   <= 1'b0;
          m_disable <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the single low-level I2C master between two command requesters, e.g. the nunchuck poller and a second sensor/config driver. Arbitrates round-robin, latches the winning command, issues a one-cycle start pulse to the master and waits for its done. Returns the read data with a one-cycle ack to the owner, and aborts with an error on timeout or illegal command. Sits between the per-device driver FSMs and the `I2C` instance, in the `i2c_clock` domain.

## Interface
Parameters:
- MAX_BYTES, 6, max bytes per transfer; sets data bus width 8*MAX_BYTES (byte k at bits [8k+7:8k]).
- TIMEOUT, 4095, WAIT-state cycles before abort; counter width $clog2(TIMEOUT+1).

Ports:
- clock  in  1  single clock (the I2C-rate clock); all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request level; held with fields stable until the matching ack.
- dev_addr0, dev_addr1  in  7  7-bit device address.
- reg_addr0, reg_addr1  in  8  register address.
- num_bytes0, num_bytes1  in  4  bytes to transfer.
- write0, write1  in  1  1 = write, 0 = read.
- wdata0, wdata1  in  8*MAX_BYTES  write payload.
- ack0, ack1  out  1  one-cycle completion pulse to the owner.
- err  out  1  valid with ack; 1 = timeout or illegal command.
- rdata  out  8*MAX_BYTES  read data; valid in the ack cycle, held until the next ack.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or last granted requester.
- m_disable  out  1  master disable; high in IDLE.
- m_start  out  1  one-cycle start pulse to the master (its `communicate`).
- m_dev_addr 7, m_addr 8, m_num_bytes 4, m_write 1, m_wdata 8*MAX_BYTES  out  latched command.
- m_done  in  1  master done level.
- m_rdata  in  8*MAX_BYTES  master read data.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requesting, grant the requester not equal to last_owner.
  - On grant: latch the grantee's fields into m_*, set owner.
  - Illegal command (num_bytes > MAX_BYTES, or read with num_bytes == 0): skip the master, go to FINISH with err_pending = 1.
  - Otherwise go to ISSUE.
- ISSUE: m_disable = 0, m_start = 1 for exactly this cycle, clear the timeout counter, then go to WAIT.
- WAIT:
  - m_disable = 0; the counter increments each cycle.
  - Done is detected on a rising edge only: m_done & ~m_done_q, where m_done_q is registered every cycle. A done level left high from a prior transaction is not accepted.
  - On done edge: capture m_rdata into rdata if read (rdata unchanged on write); err_pending = 0; go to FINISH.
  - Counter reaches TIMEOUT without a done edge: err_pending = 1, rdata unchanged, go to FINISH.
  - Done edge and timeout in the same cycle: done wins, err = 0.
- FINISH:
  - ack[owner] = 1, err = err_pending, m_disable = 1.
  - last_owner <= owner; go to IDLE.
- The requester drops req in the cycle after its ack. A req still high then is treated as a new request and competes normally.
- Requests arriving while busy wait; they are never dropped.

## Timing
- Reset values: state IDLE, ack0/1 = 0, err = 0, rdata = 0, busy = 0, owner = 0, last_owner = 1 (requester 0 wins the first tie), m_disable = 1, m_start = 0, m_* = 0, counter = 0, m_done_q = 0.
- Reset asserted mid-transaction: next cycle is IDLE with reset values. No ack is issued and the pending command is discarded.
- Legal command path:
  - req seen in IDLE at cycle 0 → ISSUE at cycle 1 (m_start high) → WAIT from cycle 2.
  - Done edge at cycle k → ack at k+1 → IDLE at k+2; the next grant can be decided at k+2.
- Illegal command path: req at cycle 0 → ack + err at cycle 1, m_start never pulses.
- Timeout path: ack + err at cycle 2+TIMEOUT+1.
- ack is never asserted for both requesters in the same cycle. m_start is never high outside ISSUE.

## Test plan
- Single write: req0, dev 0x52, reg 0xF0, num 1, wdata byte0 0x55; done edge 10 cycles after m_start → m_start one cycle, m_addr 0xF0, ack0 at done+1, err 0, ack1 never high.
- Read capture: req1 read, num 6; m_rdata 0x010203040506 at done edge → ack1 with rdata equal to it; rdata holds after ack.
- Contention: req0 and req1 both high from reset and held → order 0,1,0,1 across four transactions; each ack one cycle, never simultaneous.
- Timeout: TIMEOUT=16, m_done held low → ack0 with err 1 at 19 cycles after the grant cycle, m_disable high afterward; a following normal transaction completes with err 0.
- Stale done / illegal command:
  - m_done held high before ISSUE → no completion until it falls and rises again.
  - Read with num 0 → ack + err next cycle, no m_start.
- Reset mid-WAIT → no ack, m_disable 1, state IDLE. Re-request completes normally, and requester 0 wins a tie.
